fabric_switch_buffered: RTL and testbench

Buffered successor to the combinational fabric switch. It keeps the compile-time CONNECTIVITY matrix, the compressed runtime route table and atomic broadcast. It adds a per-output FIFO of parameterised depth, so out_ready never reaches in_ready combinationally and switches can be cascaded without long ready chains. It sits between PEs and fabric channels wherever a routing point also needs elastic buffering.

---
 rtl/fabric_switch_buffered.sv | 220 ++++++++++++++++++++++
 tb/tb_fabric_switch_buffered.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_switch_buffered.sv
// fabric_switch_buffered
//   Routing crossbar with a FIFO on every output. Inputs are steered by a
//   runtime route table (compressed over the compile-time CONNECTIVITY
//   matrix). A broadcast pushes into all targeted FIFOs on the same edge, or
//   into none of them. in_ready is built only from registered FIFO counts and
//   the route configuration, so out_ready never reaches in_ready
//   combinationally.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/ready    : per-input handshake, in_data per-input payload
//   out_valid/ready   : per-output handshake, out_data = FIFO head (0 if empty)
//   out_count         : per-output FIFO occupancy
//   cfg_route_table   : one bit per set CONNECTIVITY bit, output-major, LSB first
//   error_valid/code  : sticky first error (1 = mixed routes, 262 = unrouted input)

// Per-output circular FIFO; depth need not be a power of two.
module fabric_switch_buffered_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 32,
   parameter int CW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [W-1:0]  o_data,
   output logic [CW-1:0] o_count,
   output logic          o_full
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;
   // A full FIFO refuses a push even when it pops on the same edge.
   assign w_push  = i_push & ~o_full;
   assign w_pop   = o_valid & i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage is not reset; stale words are hidden because o_data is gated by count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end
endmodule

module fabric_switch_buffered #(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_OUTPUTS = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int TAG_WIDTH   = 0,
   parameter logic [NUM_OUTPUTS*NUM_INPUTS-1:0] CONNECTIVITY = '1,
   parameter int FIFO_DEPTH  = 2,
   localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
   localparam int NUM_CONNECTED = $countones(CONNECTIVITY),
   localparam int CNT_WIDTH     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NUM_INPUTS-1:0]                       in_valid,
   output logic [NUM_INPUTS-1:0]                       in_ready,
   input  logic [NUM_INPUTS-1:0][PAYLOAD_WIDTH-1:0]    in_data,
   output logic [NUM_OUTPUTS-1:0]                      out_valid,
   input  logic [NUM_OUTPUTS-1:0]                      out_ready,
   output logic [NUM_OUTPUTS-1:0][PAYLOAD_WIDTH-1:0]   out_data,
   output logic [NUM_OUTPUTS-1:0][CNT_WIDTH-1:0]       out_count,
   input  logic [NUM_CONNECTED-1:0]                    cfg_route_table,
   output logic                                        error_valid,
   output logic [15:0]                                 error_code
);
   // Position of CONNECTIVITY bit 'pos' inside the compressed route table.
   function automatic int f_rank(input int pos);
      int n;
      n = 0;
      for (int b = 0; b < pos; b++) if (CONNECTIVITY[b]) n++;
      return n;
   endfunction

   function automatic logic [NUM_INPUTS-1:0] f_col_mask();
      logic [NUM_INPUTS-1:0] m;
      m = '0;
      for (int o = 0; o < NUM_OUTPUTS; o++)
         for (int i = 0; i < NUM_INPUTS; i++)
            if (CONNECTIVITY[o*NUM_INPUTS+i]) m[i] = 1'b1;
      return m;
   endfunction

   localparam logic [NUM_INPUTS-1:0] COL_CONN = f_col_mask();

   if (NUM_INPUTS < 1 || NUM_INPUTS > 32 || NUM_OUTPUTS < 1 || NUM_OUTPUTS > 32) begin : g_port_chk
      $fatal(1, "COMP_SWITCH_PORT_LIMIT");
   end
   if (FIFO_DEPTH < 1) begin : g_depth_chk
      $fatal(1, "FIFO_DEPTH must be >= 1");
   end
   for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_row_chk
      if (CONNECTIVITY[o*NUM_INPUTS +: NUM_INPUTS] == '0) begin : g_err
         $fatal(1, "COMP_SWITCH_ROW_EMPTY");
      end
   end
   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_col_chk
      if (!COL_CONN[i]) begin : g_err
         $fatal(1, "COMP_SWITCH_COL_EMPTY");
      end
   end

   logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0]    w_route;
   logic [NUM_INPUTS-1:0]                     w_routed;
   logic [NUM_INPUTS-1:0]                     w_blocked;
   logic [NUM_INPUTS-1:0]                     w_fire;
   logic [NUM_INPUTS-1:0]                     w_unrouted;
   logic                                      w_mix;
   logic [NUM_OUTPUTS-1:0]                    w_full;
   logic [NUM_OUTPUTS-1:0]                    w_push;
   logic [NUM_OUTPUTS-1:0][PAYLOAD_WIDTH-1:0] w_pdata;
   logic                                      r_err_valid;
   logic [15:0]                               r_err_code;

   // Expand the compressed table; unconnected crosspoints are tied to 0.
   for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_rm_o
      for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_rm_i
         if (CONNECTIVITY[o*NUM_INPUTS+i]) begin : g_on
            assign w_route[o][i] = cfg_route_table[f_rank(o*NUM_INPUTS+i)];
         end else begin : g_off
            assign w_route[o][i] = 1'b0;
         end
      end
   end

   always_comb begin
      w_routed  = '0;
      w_mix     = 1'b0;
      w_blocked = '0;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         w_routed = w_routed | w_route[o];
         // x & (x-1) is nonzero when more than one bit is set
         if ((w_route[o] & (w_route[o] - NUM_INPUTS'(1))) != '0) w_mix = 1'b1;
         for (int i = 0; i < NUM_INPUTS; i++)
            if (w_route[o][i] && w_full[o]) w_blocked[i] = 1'b1;
      end
      in_ready   = w_routed & ~w_blocked & {NUM_INPUTS{~w_mix & ~rst}};
      w_fire     = in_valid & in_ready;
      w_unrouted = in_valid & COL_CONN & ~w_routed;
   end

   // With no mix error each output has at most one source, so OR-muxing is safe.
   always_comb begin
      w_push  = '0;
      w_pdata = '0;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_route[o][i] && w_fire[i]) begin
               w_push[o]  = 1'b1;
               w_pdata[o] = w_pdata[o] | in_data[i];
            end
         end
      end
   end

   for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
      fabric_switch_buffered_fifo #(
         .DEPTH (FIFO_DEPTH),
         .W     (PAYLOAD_WIDTH),
         .CW    (CNT_WIDTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .i_push  (w_push[o]),
         .i_data  (w_pdata[o]),
         .i_ready (out_ready[o]),
         .o_valid (out_valid[o]),
         .o_data  (out_data[o]),
         .o_count (out_count[o]),
         .o_full  (w_full[o])
      );
   end

   // First error wins and sticks until reset; lower code has priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_valid <= 1'b0;
         r_err_code  <= '0;
      end else if (!r_err_valid) begin
         if (w_mix) begin
            r_err_valid <= 1'b1;
            r_err_code  <= 16'd1;
         end else if (|w_unrouted) begin
            r_err_valid <= 1'b1;
            r_err_code  <= 16'd262;
         end
      end
   end

   assign error_valid = r_err_valid;
   assign error_code  = r_err_code;
endmodule

// File: tb/tb_fabric_switch_buffered.sv
// Bench for fabric_switch_buffered: two instances (4x4 sparse, depth 2 and
// 2x2 full, depth 1) checked every cycle against a queue-based model, plus
// directed scenarios with hand-computed literal expectations.
module tb_fabric_switch_buffered;
   localparam int          MNI   [2] = '{4, 2};
   localparam int          MNO   [2] = '{4, 2};
   localparam int          MDEP  [2] = '{2, 1};
   localparam logic [15:0] MCONN [2] = '{16'hEFF7, 16'h000F};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance 0: 4x4, CONNECTIVITY 0xEFF7 (in3->out0 and in0->out3 absent), 14 route bits
   logic [3:0]       iv0, ordy0, ir0, ov0;
   logic [3:0][15:0] id0, od0;
   logic [3:0][1:0]  oc0;
   logic [13:0]      cfg0;
   logic             ev0;
   logic [15:0]      ec0;
   // instance 1: 2x2 full, depth 1
   logic [1:0]       iv1, ordy1, ir1, ov1;
   logic [1:0][7:0]  id1, od1;
   logic [1:0]       oc1;
   logic [3:0]       cfg1;
   logic             ev1;
   logic [15:0]      ec1;

   fabric_switch_buffered #(.NUM_INPUTS(4), .NUM_OUTPUTS(4), .DATA_WIDTH(12), .TAG_WIDTH(4),
      .CONNECTIVITY(16'hEFF7), .FIFO_DEPTH(2)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
      .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_count(oc0),
      .cfg_route_table(cfg0), .error_valid(ev0), .error_code(ec0));

   fabric_switch_buffered #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .DATA_WIDTH(8), .TAG_WIDTH(0),
      .CONNECTIVITY(4'hF), .FIFO_DEPTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
      .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_count(oc1),
      .cfg_route_table(cfg1), .error_valid(ev1), .error_code(ec1));

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // model state
   logic [15:0] mq [2][4][$];
   bit          mev [2];
   logic [15:0] mec [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic get_in(input int k, output logic [3:0] v, output logic [3:0][15:0] d,
                         output logic [3:0] r, output logic [15:0] c);
      d = '0;
      if (k == 0) begin
         v = iv0; d = id0; r = ordy0; c = 16'(cfg0);
      end else begin
         v = {2'b00, iv1}; r = {2'b00, ordy1}; c = 16'(cfg1);
         d[0] = 16'(id1[0]); d[1] = 16'(id1[1]);
      end
   endtask

   task automatic get_out(input int k, output logic [3:0] ov, output logic [3:0][15:0] od,
                          output logic [3:0][3:0] oc, output logic [3:0] ir,
                          output logic ev, output logic [15:0] ec);
      od = '0; oc = '0;
      if (k == 0) begin
         ov = ov0; od = od0; ir = ir0; ev = ev0; ec = ec0;
         for (int o = 0; o < 4; o++) oc[o] = 4'(oc0[o]);
      end else begin
         ov = {2'b00, ov1}; ir = {2'b00, ir1}; ev = ev1; ec = ec1;
         for (int o = 0; o < 2; o++) begin
            od[o] = 16'(od1[o]);
            oc[o] = 4'(oc1[o]);
         end
      end
   endtask

   // route table -> rm[o][i], walking connected crosspoints output-major
   function automatic logic [3:0][3:0] expand(input int k, input logic [15:0] c);
      logic [3:0][3:0] rm;
      logic [15:0] cm;
      int j;
      rm = '0; j = 0; cm = MCONN[k];
      for (int o = 0; o < MNO[k]; o++)
         for (int i = 0; i < MNI[k]; i++)
            if (cm[o*MNI[k]+i]) begin
               rm[o][i] = c[j];
               j++;
            end
      return rm;
   endfunction

   function automatic logic [15:0] compress(input int k, input logic [3:0][3:0] rm);
      logic [15:0] c;
      logic [15:0] cm;
      int j;
      c = '0; j = 0; cm = MCONN[k];
      for (int o = 0; o < MNO[k]; o++)
         for (int i = 0; i < MNI[k]; i++)
            if (cm[o*MNI[k]+i]) begin
               c[j] = rm[o][i];
               j++;
            end
      return c;
   endfunction

   function automatic bit is_mix(input logic [3:0][3:0] rm);
      for (int o = 0; o < 4; o++) if ($countones(rm[o]) > 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] routed(input logic [3:0][3:0] rm);
      return rm[0] | rm[1] | rm[2] | rm[3];
   endfunction

   function automatic logic [3:0] col_mask(input int k);
      logic [3:0] m;
      logic [15:0] cm;
      m = '0; cm = MCONN[k];
      for (int o = 0; o < MNO[k]; o++)
         for (int i = 0; i < MNI[k]; i++)
            if (cm[o*MNI[k]+i]) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [3:0] exp_ready(input int k, input logic [3:0][3:0] rm);
      logic [3:0] rr;
      logic [3:0] rt;
      rr = '0;
      if (rst || is_mix(rm)) return rr;
      rt = routed(rm);
      for (int i = 0; i < MNI[k]; i++) begin
         rr[i] = rt[i];
         for (int o = 0; o < MNO[k]; o++)
            if (rm[o][i] && mq[k][o].size() >= MDEP[k]) rr[i] = 1'b0;
      end
      return rr;
   endfunction

   task automatic model_update(input int k);
      logic [3:0] v, r, rdy;
      logic [3:0][15:0] d;
      logic [15:0] c;
      logic [3:0][3:0] rm;
      get_in(k, v, d, r, c);
      if (rst) begin
         for (int o = 0; o < 4; o++) mq[k][o].delete();
         mev[k] = 1'b0;
         mec[k] = '0;
         return;
      end
      rm  = expand(k, c);
      rdy = exp_ready(k, rm);
      if (!mev[k]) begin
         if (is_mix(rm)) begin
            mev[k] = 1'b1; mec[k] = 16'd1;
         end else if ((v & col_mask(k) & ~routed(rm)) != '0) begin
            mev[k] = 1'b1; mec[k] = 16'd262;
         end
      end
      for (int o = 0; o < MNO[k]; o++)
         if (mq[k][o].size() != 0 && r[o]) void'(mq[k][o].pop_front());
      for (int i = 0; i < MNI[k]; i++)
         if (v[i] && rdy[i])
            for (int o = 0; o < MNO[k]; o++)
               if (rm[o][i]) mq[k][o].push_back(d[i]);
   endtask

   task automatic compare(input int k);
      logic [3:0] v, r, ov, ir, rdy;
      logic [3:0][15:0] d, od;
      logic [3:0][3:0] oc;
      logic [15:0] c, ec;
      logic ev;
      int sz;
      get_in(k, v, d, r, c);
      get_out(k, ov, od, oc, ir, ev, ec);
      rdy = exp_ready(k, expand(k, c));
      for (int o = 0; o < MNO[k]; o++) begin
         sz = mq[k][o].size();
         chk($sformatf("u%0d out_valid[%0d]", k, o), 32'(ov[o]), 32'(sz != 0));
         chk($sformatf("u%0d out_data[%0d]", k, o), 32'(od[o]), (sz != 0) ? 32'(mq[k][o][0]) : 32'd0);
         chk($sformatf("u%0d out_count[%0d]", k, o), 32'(oc[o]), 32'(sz));
      end
      for (int i = 0; i < MNI[k]; i++)
         chk($sformatf("u%0d in_ready[%0d]", k, i), 32'(ir[i]), 32'(rdy[i]));
      chk($sformatf("u%0d error_valid", k), 32'(ev), 32'(mev[k]));
      chk($sformatf("u%0d error_code", k), 32'(ec), 32'(mec[k]));
   endtask

   initial forever begin
      @(posedge clk);
      model_update(0);
      model_update(1);
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         compare(0);
         compare(1);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_cfg(input int k, output logic [15:0] c, output logic [3:0] rmask);
      logic [3:0][3:0] rm;
      logic [15:0] cm;
      int p;
      rm = '0; cm = MCONN[k];
      for (int o = 0; o < MNO[k]; o++) begin
         p = $urandom_range(0, MNI[k]);
         if (p < MNI[k] && cm[o*MNI[k]+p]) rm[o][p] = 1'b1;
         if ($urandom_range(0, 15) == 0) begin
            p = $urandom_range(0, MNI[k] - 1);
            if (cm[o*MNI[k]+p]) rm[o][p] = 1'b1;
         end
      end
      c = compress(k, rm);
      rmask = routed(rm);
   endtask

   initial begin
      logic [15:0] c;
      logic [3:0]  m0, m1;
      int sent;
      bit was_rdy;
      iv0 = '0; id0 = '0; ordy0 = '0; cfg0 = '0;
      iv1 = '0; id1 = '0; ordy1 = '0; cfg1 = '0;
      m0 = '0; m1 = '0;
      cyc(2);
      rst = 1'b0;
      chk_en = 1'b1;

      // straight routes in0->out0, in1->out1; back-to-back stream
      cfg0 = 14'h11; ordy0 = 4'hF;
      #1 chk("t1 in_ready0 idle", 32'(ir0[0]), 32'd1);
      iv0 = 4'b0001; id0[0] = 16'hA5;
      cyc(1);
      chk("t1 head A5", 32'(od0[0]), 32'hA5);
      chk("t1 in_ready0", 32'(ir0[0]), 32'd1);
      id0[0] = 16'hA6;
      cyc(1);
      chk("t1 head A6", 32'(od0[0]), 32'hA6);
      chk("t1 in_ready0", 32'(ir0[0]), 32'd1);
      id0[0] = 16'hA7;
      cyc(1);
      chk("t1 head A7", 32'(od0[0]), 32'hA7);
      iv0 = '0;
      cyc(1);
      chk("t1 drained", 32'(ov0[0]), 32'd0);

      // broadcast in0->out0,out1 with out1 stalled
      cfg0 = 14'h9; ordy0 = 4'b0001; iv0 = 4'b0001;
      for (int n = 0; n < 4; n++) begin
         id0[0] = 16'hB0 + 16'(n);
         cyc(1);
      end
      chk("t2 out1 count", 32'(oc0[1]), 32'd2);
      chk("t2 in_ready0 blocked", 32'(ir0[0]), 32'd0);
      chk("t2 out0 empty", 32'(ov0[0]), 32'd0);
      ordy0 = 4'b0011;
      cyc(1);
      chk("t2 in_ready0 back", 32'(ir0[0]), 32'd1);
      chk("t2 out1 head B1", 32'(od0[1]), 32'hB1);
      cyc(1);
      iv0 = '0;
      cyc(4);

      // prior word in out0, then in0+in1 both routed to out0
      cfg0 = 14'h1; ordy0 = '0; iv0 = 4'b0001; id0[0] = 16'hC0;
      chk("t3 no error yet", 32'(ev0), 32'd0);
      cyc(1);
      iv0 = '0; cfg0 = 14'h3;
      #1 chk("t3 mix blocks all", 32'(ir0), 32'd0);
      cyc(1);
      chk("t3 error_valid", 32'(ev0), 32'd1);
      chk("t3 error_code", 32'(ec0), 32'd1);
      chk("t3 buffered C0", 32'(od0[0]), 32'hC0);
      ordy0 = 4'hF;
      cyc(1);
      chk("t3 C0 drained", 32'(ov0[0]), 32'd0);

      // unrouted input error, then a later mix error must not override
      rst = 1'b1;
      cyc(1);
      rst = 1'b0; cfg0 = '0; iv0 = 4'b0100; id0[2] = 16'h0222;
      cyc(1);
      chk("t4 error_valid", 32'(ev0), 32'd1);
      chk("t4 error_code", 32'(ec0), 32'd262);
      iv0 = '0; cfg0 = 14'h3;
      cyc(2);
      chk("t4 code sticky", 32'(ec0), 32'd262);

      // reset drops buffered words
      rst = 1'b1;
      cyc(1);
      rst = 1'b0; cfg0 = 14'h11; ordy0 = '0; iv0 = 4'b0001; id0[0] = 16'hD0;
      cyc(1);
      id0[0] = 16'hD1;
      cyc(1);
      iv0 = '0;
      chk("t5 count before rst", 32'(oc0[0]), 32'd2);
      rst = 1'b1;
      #1 chk("t5 in_ready1 in rst", 32'(ir0[1]), 32'd0);
      cyc(1);
      rst = 1'b0;
      chk("t5 out_valid after rst", 32'(ov0[0]), 32'd0);
      chk("t5 out_count after rst", 32'(oc0[0]), 32'd0);
      chk("t5 error_valid after rst", 32'(ev0), 32'd0);
      iv0 = 4'b0001; id0[0] = 16'hD2;
      cyc(1);
      iv0 = '0;
      chk("t5 fresh push head", 32'(od0[0]), 32'hD2);
      chk("t5 fresh push valid", 32'(ov0[0]), 32'd1);
      cyc(2);

      // depth 1: accepts every other cycle
      cfg1 = 4'b0001; ordy1 = 2'b11; iv1 = 2'b01; sent = 0; id1[0] = 8'h10;
      for (int n = 0; n < 8; n++) begin
         #1;
         chk($sformatf("t6 in_ready toggle %0d", n), 32'(ir1[0]), 32'(n % 2 == 0));
         was_rdy = ir1[0] && iv1[0];
         cyc(1);
         if (was_rdy) begin
            chk($sformatf("t6 head %0d", n), 32'(od1[0]), 32'h10 + 32'(sent));
            sent++;
            id1[0] = 8'h10 + 8'(sent);
            if (sent == 4) iv1 = '0;
         end
      end
      chk("t6 words sent", 32'(sent), 32'd4);

      // randomized traffic, reconfiguration and occasional resets
      for (int n = 0; n < 3000; n++) begin
         if (n % 8 == 0) begin
            rand_cfg(0, c, m0); cfg0 = c[13:0];
            rand_cfg(1, c, m1); cfg1 = c[3:0];
         end
         iv0 = 4'($urandom) & (($urandom_range(0, 9) == 0) ? 4'hF : m0);
         for (int i = 0; i < 4; i++) id0[i] = 16'($urandom);
         ordy0 = 4'($urandom | $urandom);
         iv1 = 2'($urandom) & (($urandom_range(0, 9) == 0) ? 2'b11 : m1[1:0]);
         for (int i = 0; i < 2; i++) id1[i] = 8'($urandom);
         ordy1 = 2'($urandom | $urandom);
         rst = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      rst = 1'b0; iv0 = '0; iv1 = '0;
      cyc(3);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
